// File: rtl/alu_muxes_pkg.sv
// Shared constants for the EX-stage operand selection block.
// Holds forwarding select encodings and default operand widths.
package alu_muxes_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_W_DEF  = 3;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage : alu_muxes_pkg

// File: rtl/alu_muxes_fwd_mux3.sv
// Three-source forwarding mux: register file value, EX/MEM result or MEM/WB result.
// The unused code 2'b11 falls back to the register file value.
module fwd_mux3
   import alu_muxes_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] reg_val,
   input  logic [DATA_W-1:0] mem_val,
   input  logic [DATA_W-1:0] wb_val,
   output logic [DATA_W-1:0] y
);

   // A case keeps an X on a deselected source from reaching y.
   always_comb begin
      y = reg_val;
      case (sel)
         FWD_MEM: y = mem_val;
         FWD_WB:  y = wb_val;
         default: y = reg_val;
      endcase
   end

endmodule : fwd_mux3

// File: rtl/alu_muxes.sv
// EX-stage operand selection: destination register, operand forwarding,
// immediate select and store data, with an optional output register stage.
module alu_muxes
   import alu_muxes_pkg::*;
#(
   parameter int DATA_W           = DATA_W_DEF,
   parameter int REG_W            = REG_W_DEF,
   parameter bit REGISTER_OUTPUTS = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegDst,
   input  logic [REG_W-1:0]  Rt,
   input  logic [REG_W-1:0]  Rd,
   output logic [REG_W-1:0]  DestReg,
   input  logic              ALUSrc,
   input  logic [1:0]        ForwardA,
   input  logic [1:0]        ForwardB,
   input  logic [DATA_W-1:0] Mem_ALUOut,
   input  logic [DATA_W-1:0] WB_WriteData,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [DATA_W-1:0] Imm,
   output logic [DATA_W-1:0] Operand1,
   output logic [DATA_W-1:0] Operand2,
   output logic [DATA_W-1:0] StoreData
);

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic [REG_W-1:0]  dest_reg_d;
   logic [DATA_W-1:0] operand1_d;
   logic [DATA_W-1:0] operand2_d;
   logic [DATA_W-1:0] store_data_d;

   fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_a (
      .sel     (ForwardA),
      .reg_val (ReadData1),
      .mem_val (Mem_ALUOut),
      .wb_val  (WB_WriteData),
      .y       (fwd_a)
   );

   fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_b (
      .sel     (ForwardB),
      .reg_val (ReadData2),
      .mem_val (Mem_ALUOut),
      .wb_val  (WB_WriteData),
      .y       (fwd_b)
   );

   // Store data always takes the forwarded B value; Imm only steers the ALU.
   always_comb begin
      dest_reg_d   = RegDst ? Rd : Rt;
      operand1_d   = fwd_a;
      operand2_d   = ALUSrc ? Imm : fwd_b;
      store_data_d = fwd_b;
   end

   generate
      if (REGISTER_OUTPUTS) begin : g_reg
         logic [REG_W-1:0]  dest_reg_q;
         logic [DATA_W-1:0] operand1_q;
         logic [DATA_W-1:0] operand2_q;
         logic [DATA_W-1:0] store_data_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               dest_reg_q   <= '0;
               operand1_q   <= '0;
               operand2_q   <= '0;
               store_data_q <= '0;
            end else begin
               dest_reg_q   <= dest_reg_d;
               operand1_q   <= operand1_d;
               operand2_q   <= operand2_d;
               store_data_q <= store_data_d;
            end
         end

         assign DestReg   = dest_reg_q;
         assign Operand1  = operand1_q;
         assign Operand2  = operand2_q;
         assign StoreData = store_data_q;
      end else begin : g_comb
         // clk and rst have no function in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;

         assign DestReg   = dest_reg_d;
         assign Operand1  = operand1_d;
         assign Operand2  = operand2_d;
         assign StoreData = store_data_d;
      end
   endgenerate

endmodule : alu_muxes

// File: tb/tb_alu_muxes.sv
// Directed bench for alu_muxes: combinational and registered builds driven
// from the same inputs, checked against hand-computed values.
module tb_alu_muxes;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegDst;
   logic [2:0]  Rt, Rd;
   logic        ALUSrc;
   logic [1:0]  ForwardA, ForwardB;
   logic [15:0] Mem_ALUOut, WB_WriteData, ReadData1, ReadData2, Imm;

   logic [2:0]  c_dest, r_dest;
   logic [15:0] c_op1, c_op2, c_st;
   logic [15:0] r_op1, r_op2, r_st;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_muxes #(.DATA_W(16), .REG_W(3), .REGISTER_OUTPUTS(1'b0)) u_comb (
      .clk(clk), .rst(rst), .RegDst(RegDst), .Rt(Rt), .Rd(Rd), .DestReg(c_dest),
      .ALUSrc(ALUSrc), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .Mem_ALUOut(Mem_ALUOut), .WB_WriteData(WB_WriteData),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm),
      .Operand1(c_op1), .Operand2(c_op2), .StoreData(c_st)
   );

   alu_muxes #(.DATA_W(16), .REG_W(3), .REGISTER_OUTPUTS(1'b1)) u_reg (
      .clk(clk), .rst(rst), .RegDst(RegDst), .Rt(Rt), .Rd(Rd), .DestReg(r_dest),
      .ALUSrc(ALUSrc), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .Mem_ALUOut(Mem_ALUOut), .WB_WriteData(WB_WriteData),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm),
      .Operand1(r_op1), .Operand2(r_op2), .StoreData(r_st)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic check_comb(input string tag, input logic [2:0] d,
                             input logic [15:0] o1, input logic [15:0] o2, input logic [15:0] s);
      check({tag, " comb DestReg"},   {13'd0, c_dest}, {13'd0, d});
      check({tag, " comb Operand1"},  c_op1, o1);
      check({tag, " comb Operand2"},  c_op2, o2);
      check({tag, " comb StoreData"}, c_st,  s);
   endtask

   task automatic check_reg(input string tag, input logic [2:0] d,
                            input logic [15:0] o1, input logic [15:0] o2, input logic [15:0] s);
      check({tag, " reg DestReg"},   {13'd0, r_dest}, {13'd0, d});
      check({tag, " reg Operand1"},  r_op1, o1);
      check({tag, " reg Operand2"},  r_op2, o2);
      check({tag, " reg StoreData"}, r_st,  s);
   endtask

   initial begin
      rst = 1'b1;
      Rt = 3'd1; Rd = 3'd2;
      ReadData1 = 16'h1111; ReadData2 = 16'h2222;
      Mem_ALUOut = 16'hAAAA; WB_WriteData = 16'hBBBB; Imm = 16'hFFFF;
      RegDst = 1'b0; ALUSrc = 1'b0; ForwardA = 2'b00; ForwardB = 2'b00;

      // Reset held for two edges with live inputs: registered outputs stay zero.
      repeat (2) @(posedge clk);
      #1;
      check_reg("rst hold", 3'd0, 16'h0, 16'h0, 16'h0);

      // Scenario 1
      check_comb("s1", 3'd1, 16'h1111, 16'h2222, 16'h2222);

      // Scenario 2
      RegDst = 1'b1; ALUSrc = 1'b1; ForwardA = 2'b00; ForwardB = 2'b01;
      #1;
      check_comb("s2", 3'd2, 16'h1111, 16'hFFFF, 16'hBBBB);

      // Scenario 3
      ALUSrc = 1'b0; ForwardA = 2'b10; ForwardB = 2'b01;
      #1;
      check_comb("s3", 3'd2, 16'hAAAA, 16'hBBBB, 16'hBBBB);

      // Scenario 4
      ForwardA = 2'b01; ForwardB = 2'b10;
      #1;
      check_comb("s4a", 3'd2, 16'hBBBB, 16'hAAAA, 16'hAAAA);
      RegDst = 1'b0; ForwardA = 2'b00; ForwardB = 2'b00;
      #1;
      check_comb("s4b", 3'd1, 16'h1111, 16'h2222, 16'h2222);

      // Scenario 5: illegal code 11 behaves as no forward
      ForwardA = 2'b11; ForwardB = 2'b11; ALUSrc = 1'b0;
      #1;
      check_comb("s5", 3'd1, 16'h1111, 16'h2222, 16'h2222);

      // Imm selected while ForwardB points at EX/MEM: Operand2 takes Imm, StoreData keeps forward
      ALUSrc = 1'b1; ForwardB = 2'b10; ForwardA = 2'b01;
      #1;
      check_comb("imm ovr", 3'd1, 16'hBBBB, 16'hFFFF, 16'hAAAA);

      // X on unselected sources must not leak
      ALUSrc = 1'b0; ForwardA = 2'b00; ForwardB = 2'b01;
      Mem_ALUOut = 16'hxxxx; Imm = 16'hxxxx; Rd = 3'bxxx; ReadData2 = 16'hxxxx;
      #1;
      check_comb("x iso", 3'd1, 16'h1111, 16'hBBBB, 16'hBBBB);
      Mem_ALUOut = 16'hAAAA; Imm = 16'hFFFF; Rd = 3'd2; ReadData2 = 16'h2222;
      #1;

      // Scenario 6: registered build
      @(negedge clk);
      rst = 1'b0;
      RegDst = 1'b1; ALUSrc = 1'b0; ForwardA = 2'b10; ForwardB = 2'b01;
      #1;
      check_reg("s6 pre-edge", 3'd0, 16'h0, 16'h0, 16'h0);
      @(posedge clk); #1;
      check_reg("s6 edge1", 3'd2, 16'hAAAA, 16'hBBBB, 16'hBBBB);

      @(negedge clk);
      ForwardA = 2'b01; ForwardB = 2'b10;
      #1;
      check("s6 latency Operand1", r_op1, 16'hAAAA);
      @(posedge clk); #1;
      check_reg("s6 edge2", 3'd2, 16'hBBBB, 16'hAAAA, 16'hAAAA);

      @(negedge clk);
      rst = 1'b1;
      #1;
      check("s6 rst pre-edge Operand1", r_op1, 16'hBBBB);
      @(posedge clk); #1;
      check_reg("s6 rst", 3'd0, 16'h0, 16'h0, 16'h0);

      @(negedge clk);
      rst = 1'b0;
      ALUSrc = 1'b1; RegDst = 1'b0;
      #1;
      check("s6 release pre-edge Operand2", r_op2, 16'h0);
      @(posedge clk); #1;
      check_reg("s6 release", 3'd1, 16'hBBBB, 16'hFFFF, 16'hAAAA);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_alu_muxes

// File: doc/alu_muxes.md
Name: alu_muxes

Overview:
- EX-stage operand selection block of the 16-bit, 5-stage pipelined processor.
- Picks the destination register (Rt or Rd), applies EX/MEM and MEM/WB forwarding to both register operands, and picks register or immediate for ALU operand 2.
- Also exports the forwarded second register value as store data for the MEM stage.
- Purely combinational by default; an optional output register stage uses the clock and reset.

Parameters:
- DATA_W, 16, width of data operands.
- REG_W, 3, width of register specifiers.
- REGISTER_OUTPUTS, 0, 0 = outputs combinational; 1 = outputs registered on clk.

Ports:
- clk  in  1  system clock; only used when REGISTER_OUTPUTS=1.
- rst  in  1  synchronous, active-high reset; only used when REGISTER_OUTPUTS=1.
- RegDst  in  1  1 selects Rd as destination, 0 selects Rt.
- Rt  in  REG_W  rt field from ID/EX.
- Rd  in  REG_W  rd field from ID/EX.
- DestReg  out  REG_W  selected destination register.
- ALUSrc  in  1  1 selects Imm for Operand2, 0 selects forwarded B.
- ForwardA  in  2  forwarding select for operand A.
- ForwardB  in  2  forwarding select for operand B.
- Mem_ALUOut  in  DATA_W  ALU result held in EX/MEM.
- WB_WriteData  in  DATA_W  write-back value held in MEM/WB.
- ReadData1  in  DATA_W  register file port 1 value from ID/EX.
- ReadData2  in  DATA_W  register file port 2 value from ID/EX.
- Imm  in  DATA_W  sign-extended immediate from ID/EX.
- Operand1  out  DATA_W  ALU input A.
- Operand2  out  DATA_W  ALU input B.
- StoreData  out  DATA_W  forwarded B value, never replaced by Imm.

Behaviour:
- Forward encoding, identical for A and B:
  - 2'b00 → ReadDataN.
  - 2'b10 → Mem_ALUOut (EX/MEM hazard).
  - 2'b01 → WB_WriteData (MEM/WB hazard).
  - 2'b11 → ReadDataN (illegal code treated as no forward).
- Operand1 = fwdA.
- fwdB is the ForwardB-selected value.
- Operand2 = ALUSrc ? Imm : fwdB. Imm overrides any ForwardB value.
- StoreData = fwdB, independent of ALUSrc.
- DestReg = RegDst ? Rd : Rt.
- No arithmetic, no width change; values pass bit-exact.
- REGISTER_OUTPUTS=0:
  - All outputs are zero-latency combinational functions of current inputs.
  - Any input change reflects in the same delta cycle.
  - clk and rst are ignored.
- REGISTER_OUTPUTS=1:
  - Outputs are the same functions, sampled on the rising edge of clk (latency 1 cycle).
  - When rst=1 at an edge, DestReg, Operand1, Operand2 and StoreData all become 0; reset takes priority over new data.
  - Reset mid-stream discards the in-flight value; the first valid output appears one edge after rst deasserts.
- No X propagation from unselected inputs: an X on an unselected source must not affect outputs.

Decomposition:
- Shared package holds:
  - Forward select constants: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - DATA_W and REG_W defaults.
- One natural sub-module: fwd_mux3, a DATA_W-wide 3-source forwarding mux instantiated twice (A and B).
- Destination and ALUSrc selection plus the optional output register stay in the top.

Test Plan:
Common inputs for scenarios 1–5: Rt=1, Rd=2, ReadData1=1111, ReadData2=2222, Mem_ALUOut=AAAA, WB_WriteData=BBBB, Imm=FFFF, REGISTER_OUTPUTS=0.
1. RegDst=0, ALUSrc=0, FwdA=00, FwdB=00 → DestReg=001, Operand1=1111, Operand2=2222, StoreData=2222.
2. RegDst=1, ALUSrc=1, FwdA=00, FwdB=01 → DestReg=010, Operand1=1111, Operand2=FFFF, StoreData=BBBB.
3. ALUSrc=0, FwdA=10, FwdB=01 → Operand1=AAAA, Operand2=BBBB.
4. FwdA=01, FwdB=10 → Operand1=BBBB, Operand2=AAAA. Then RegDst=0, FwdA=00, FwdB=00 → DestReg=001, Operand1=1111, Operand2=2222.
5. FwdA=11, FwdB=11, ALUSrc=0 → Operand1=1111, Operand2=2222.
6. REGISTER_OUTPUTS=1: hold rst=1 for 2 edges → all outputs 0. Release rst and apply scenario 3 inputs → outputs update only after the next rising edge. Assert rst again → outputs return to 0 at the following edge.
